// File: rtl/sequence_controller.sv
// 8-phase VeriRISC instruction sequencer: steps a phase counter each clock and decodes
// the PC, memory, IR, accumulator and bus-driver strobes from phase, opcode and zero.
module sequence_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_alu, is_skz, is_sto, is_jmp, is_hlt;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // The halted flag latches on the edge into OP_ADDR so the phase freezes there.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      phase_d = phase_t'(3'(phase_q + 3'd1));
      if (phase_q == IDLE && is_hlt)
        halted_d = 1'b1;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        OP_FETCH: rd = is_alu;
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_sequence_controller.sv
// Directed bench for sequence_controller: per-phase strobe tables for each opcode class,
// halt hold/exit, then a randomized run with a phase model and exclusivity checks.
module tb_sequence_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic [2:0] phase;

  int n_chk = 0;
  int n_bad = 0;

  sequence_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e}
  logic [8:0] outs;
  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};

  localparam logic [8:0] O_RESET  = 9'b100000000;
  localparam logic [8:0] O_HALTED = 9'b000100000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full instruction from phase 0; phases 0-3 are opcode independent.
  task automatic run_instr(input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] exp_t [8];
    exp_t[0] = 9'b100000000;
    exp_t[1] = 9'b110000000;
    exp_t[2] = 9'b111000000;
    exp_t[3] = 9'b111000000;
    exp_t[4] = e4;
    exp_t[5] = e5;
    exp_t[6] = e6;
    exp_t[7] = e7;
    opcode = op;
    for (int p = 0; p < 8; p++) begin
      zero = (p == 5) ? ~z : z;
      #1;
      chk($sformatf("op%0d_z%0d_ph%0d_phase", op, z, p), 32'(phase), 32'(p));
      chk($sformatf("op%0d_z%0d_ph%0d_outs", op, z, p), 32'(outs), 32'(exp_t[p]));
      step();
    end
  endtask

  logic [2:0] mphase;
  logic       mhalt;
  logic       r_now, was_rst;

  initial begin
    rst    = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    step();
    #1;
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_outs", 32'(outs), 32'(O_RESET));
    rst = 1'b0;

    // ADD, STO, JMP, SKZ taken, SKZ not taken
    run_instr(3'd2, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010000100);
    run_instr(3'd6, 1'b0, 9'b000010000, 9'b000000000, 9'b000000001, 9'b000000011);
    run_instr(3'd7, 1'b0, 9'b000010000, 9'b000000000, 9'b000001000, 9'b000001000);
    run_instr(3'd1, 1'b1, 9'b000010000, 9'b000000000, 9'b000010000, 9'b000000000);
    run_instr(3'd1, 1'b0, 9'b000010000, 9'b000000000, 9'b000000000, 9'b000000000);
    run_instr(3'd5, 1'b1, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010000100);

    // HLT: fetch phases, then sticky hold at phase 4
    opcode = 3'd0;
    zero   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      #1;
      chk($sformatf("hlt_ph%0d_phase", p), 32'(phase), 32'(p));
      step();
    end
    #1;
    chk("hlt_enter_phase", 32'(phase), 32'd4);
    chk("hlt_enter_outs", 32'(outs), 32'(O_HALTED));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) opcode = 3'd2;
      zero = i[0];
      step();
      #1;
      chk($sformatf("hlt_hold%0d_phase", i), 32'(phase), 32'd4);
      chk($sformatf("hlt_hold%0d_outs", i), 32'(outs), 32'(O_HALTED));
    end
    rst = 1'b1;
    step();
    #1;
    chk("hlt_exit_phase", 32'(phase), 32'd0);
    chk("hlt_exit_outs", 32'(outs), 32'(O_RESET));
    rst = 1'b0;

    // Randomized run with occasional resets
    mphase  = 3'd0;
    mhalt   = 1'b0;
    was_rst = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      r_now = ($urandom_range(0, 19) == 0);
      rst   = r_now;
      if (mphase == 3'd0) opcode = 3'($urandom_range(0, 7));
      zero  = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d_phase", c), 32'(phase), 32'(mphase));
      chk($sformatf("rnd%0d_inc_ld", c), 32'(inc_pc & ld_pc), 32'd0);
      chk($sformatf("rnd%0d_rd_wr", c), 32'(rd & wr), 32'd0);
      chk($sformatf("rnd%0d_ldir_sel", c), 32'(ld_ir & ~sel), 32'd0);
      if (was_rst) chk($sformatf("rnd%0d_post_rst", c), 32'(phase), 32'd0);
      if (mhalt) chk($sformatf("rnd%0d_halted_outs", c), 32'(outs), 32'(O_HALTED));
      step();
      was_rst = r_now;
      if (r_now) begin
        mphase = 3'd0;
        mhalt  = 1'b0;
      end else if (!mhalt) begin
        if (mphase == 3'd3 && opcode == 3'd0) mhalt = 1'b1;
        mphase = mphase + 3'd1;
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
